logic_net_capture: RTL and testbench
====================================

# logic_net_capture

Downstream capture stage for the `logic_net` test netlist. It samples the registered `OUT` bit once per clock while enabled and deserializes the stream into WIDTH-bit words, MSB first. Completed words pass through a 2-entry buffer with a valid/ready output. It also keeps a saturating toggle count of `OUT` for STA correlation runs. It shares `Clk` with `logic_net`; `OUT` is already launched by a flop on that clock, so no synchronizer is used.

## Interface
Parameters:
- WIDTH, 8, bits per captured word (2..32)
- NUM_WORDS, 4, words per capture run (1..255)
- CNT_W, 16, toggle counter width

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- Start  in  1  single-cycle run request; honoured only in IDLE
- Din  in  1  serial bit, connected to `logic_net` `OUT`
- Dout  out  WIDTH  head word of buffer
- Dout_valid  out  1  Dout holds a valid word
- Dout_ready  in  1  consumer accepts the word when high together with Dout_valid
- Busy  out  1  high in SHIFT
- Done  out  1  one-cycle pulse after the last word of a run is pushed or dropped
- Overflow  out  1  sticky; a completed word was dropped
- Toggles  out  CNT_W  count of Din changes since reset, saturating

## Operation
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT when Start=1. On entry, the bit counter and word counter clear.
- In SHIFT, every cycle:
  - shreg <= {shreg[WIDTH-2:0], Din}
  - bit counter increments.
  - When the bit counter reaches WIDTH-1, the word {shreg[WIDTH-2:0], Din} completes, the bit counter wraps to 0, and the word counter increments.
- SHIFT -> IDLE on the cycle the NUM_WORDS-th word completes. Done pulses in the following cycle.
- Start while in SHIFT is ignored.
- Push into the 2-entry buffer happens on word completion:
  - Accepted if the buffer is not full, or if a pop occurs in the same cycle (full plus simultaneous pop and push is legal and keeps the occupancy at 2).
  - Otherwise the word is dropped and Overflow sets. Overflow clears only on Rst.
  - The word counter advances even when the word is dropped, so run length is fixed.
- Pop happens when Dout_valid && Dout_ready. Dout_valid equals "buffer not empty". Dout is stable while Dout_valid=1 and Dout_ready=0.
- Toggles:
  - A registered copy of Din is kept, including in IDLE.
  - The counter increments whenever Din differs from the previous Din.
  - It holds at 2^CNT_W-1.
  - The first sample after reset does not count; prev resets to 0.
- Reset values: Dout=0, Dout_valid=0, Busy=0, Done=0, Overflow=0, Toggles=0. State is IDLE, the buffer is empty, and shreg and counters are 0.
- Rst mid-run aborts immediately. A partial word is discarded and Done does not pulse.

## Timing
- All outputs are registered.
- Start sampled high at edge t puts the FSM in SHIFT after t, so Busy=1 from t+1. The first Din bit is sampled at edge t+1.
- A word whose last bit is sampled at edge e appears on Dout with Dout_valid=1 after e, so it is visible in cycle e+1.
- Back-to-back: a new word completes every WIDTH cycles, and the consumer must pop at least once per WIDTH cycles to avoid overflow. A 2-entry buffer gives 2·WIDTH cycles of slack.
- For the last word at edge e: Busy=0 and Done=1 after e. Done drops after e+1.
- The earliest next Start is sampled at e+1.

## Structure
- Package `logic_net_cap_pkg` holds:
  - the FSM state enum (IDLE, SHIFT)
  - default WIDTH, NUM_WORDS and CNT_W localparams
- Sub-module `cap_fifo2` is a 2-entry, WIDTH-parameterised register FIFO with push/pop/full/empty and a same-cycle push+pop-when-full rule. The top instantiates it once.
- The top holds the FSM, shift register, counters and toggle counter.

## Test plan
- Reset, then Start with WIDTH=8, NUM_WORDS=1, Din pattern 1,0,1,0,0,1,0,1, Dout_ready=1 -> Dout=8'hA5 with Dout_valid high for exactly one cycle, 8 cycles after Start. Done pulses once. Toggles=6.
- NUM_WORDS=4, Dout_ready=0, words A5, 3C, FF, 00 -> A5 and 3C are held in the buffer and FF and 00 are dropped. Overflow=1. Raising ready pops A5 then 3C.
- Buffer full, and ready is asserted on the exact cycle the next word completes -> no drop, Overflow stays 0, occupancy stays 2.
- Rst asserted 3 bits into a word -> all outputs read 0 immediately (asynchronously), with no Done pulse. A fresh Start then captures the next word correctly.
- Start pulsed during SHIFT -> ignored; run length is unchanged.
- Din toggling every cycle for 70000 cycles with CNT_W=16 -> Toggles saturates at 16'hFFFF.

Source files
------------

// File: rtl/logic_net_cap_pkg.sv
// Shared types and default parameters for the logic_net capture stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package logic_net_cap_pkg;

  // SHIFT is encoded as 1 so the state bit doubles as the Busy flag.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_WORDS = 4;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/cap_fifo2.sv
// Two-entry register FIFO holding completed capture words; head is a flop.
// Latency: a pushed word is on dout one cycle after the push edge.
// Backpressure: a push into a full FIFO is accepted only with a same-cycle pop.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and word
//   pop        read request (ignored when empty)
//   dout       head entry (q0), held steady until popped
//   full/empty occupancy flags
module cap_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [1:0]       cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = q0;

  // q0 is always the head; a pop shifts q1 forward, so dout never muxes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) q0 <= din;
          else             q1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; with one entry the new word becomes head.
          if (cnt == 2'd1) begin
            q0 <= din;
          end else begin
            q0 <= q1;
            q1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/logic_net_capture.sv
// Deserializes the logic_net OUT bit (MSB first) into WIDTH-bit words for a fixed-length run.
// Latency: word visible on Dout the cycle after its last bit is sampled.
// Backpressure: 2-entry buffer; a word completing while full with no pop is dropped (Overflow).
//
// Ports:
//   Clk, Rst             clock, asynchronous active-high reset
//   Start                run request, honoured in IDLE only
//   Din                  serial bit from logic_net OUT (same clock domain)
//   Dout/_valid/_ready   head word of the buffer with valid/ready handshake
//   Busy, Done           run in progress / one-cycle end-of-run pulse
//   Overflow             sticky word-dropped flag
//   Toggles              saturating count of Din changes since reset
module logic_net_capture
  import logic_net_cap_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [CNT_W-1:0] Toggles
);

  localparam int              BIT_W     = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [7:0]       LAST_WORD = 8'(NUM_WORDS - 1);

  cap_state_t       state;
  cap_state_t       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       word_cnt;
  logic             word_done;
  logic             last_word;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic             prev_din;
  logic             primed;

  assign word_nxt  = {shreg[WIDTH-2:0], Din};
  assign word_done = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign last_word = word_done && (word_cnt == LAST_WORD);
  assign pop       = Dout_valid && Dout_ready;
  assign drop      = word_done && fifo_full && !pop;

  // ---- FSM: state register ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start)     state_nxt = SHIFT;
      SHIFT:   if (last_word) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    Busy = (state == SHIFT);
  end

  // ---- Shift register, counters, run status ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= last_word;
      if (drop) Overflow <= 1'b1;
      if (state == IDLE) begin
        // The last word leaves word_cnt at NUM_WORDS, so clear on entry.
        if (Start) begin
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
      end else begin
        shreg <= word_nxt;
        if (word_done) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // ---- Toggle counter: runs in every state; first post-reset sample only primes prev_din ----
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prev_din <= 1'b0;
      primed   <= 1'b0;
      Toggles  <= '0;
    end else begin
      prev_din <= Din;
      primed   <= 1'b1;
      if (primed && (Din != prev_din) && (Toggles != '1))
        Toggles <= Toggles + 1'b1;
    end
  end

  cap_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Rst),
    .push (word_done),
    .din  (word_nxt),
    .pop  (pop),
    .dout (Dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign Dout_valid = !fifo_empty;

endmodule

// File: tb/tb_logic_net_capture.sv
// Directed, table-driven bench for logic_net_capture (WIDTH=8, NUM_WORDS=4, CNT_W=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each table row shifts one word and checks the outputs after its last bit.
module tb_logic_net_capture;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Din;
  logic [7:0]  Dout;
  logic        Dout_valid;
  logic        Dout_ready;
  logic        Busy;
  logic        Done;
  logic        Overflow;
  logic [15:0] Toggles;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start;      // pulse Start before the word
    logic       start_mid;  // pulse Start in the middle of the word
    logic [7:0] word;
    logic       ready_bits; // Dout_ready while bits 7..1 are shifted
    logic       ready_last; // Dout_ready on the completing edge
    logic [7:0] exp_dout;
    logic       exp_vld;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ovf;
    int         exp_tog;    // -1: not checked for this row
  } vec_t;

  vec_t tbl[12];

  logic_net_capture #(
    .WIDTH(8),
    .NUM_WORDS(4),
    .CNT_W(16)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Din       (Din),
    .Dout      (Dout),
    .Dout_valid(Dout_valid),
    .Dout_ready(Dout_ready),
    .Busy      (Busy),
    .Done      (Done),
    .Overflow  (Overflow),
    .Toggles   (Toggles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_row(input int i);
    vec_t v;
    v = tbl[i];
    if (v.start) begin
      Start = 1'b1;
      tick();
      Start = 1'b0;
    end
    for (int b = 7; b >= 0; b--) begin
      Din        = v.word[b];
      Dout_ready = (b == 0) ? v.ready_last : v.ready_bits;
      Start      = v.start_mid && (b == 4);
      tick();
    end
    Start = 1'b0;
    chk($sformatf("row%0d dout", i), 32'(Dout),       32'(v.exp_dout));
    chk($sformatf("row%0d vld", i),  32'(Dout_valid), 32'(v.exp_vld));
    chk($sformatf("row%0d busy", i), 32'(Busy),       32'(v.exp_busy));
    chk($sformatf("row%0d done", i), 32'(Done),       32'(v.exp_done));
    chk($sformatf("row%0d ovf", i),  32'(Overflow),   32'(v.exp_ovf));
    if (v.exp_tog >= 0)
      chk($sformatf("row%0d toggles", i), 32'(Toggles), 32'(v.exp_tog));
  endtask

  initial begin
    // Run A: ready high, Start pulsed mid-run on row 2 (ignored).
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 6};
    tbl[1]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, -1};
    // Run C: fill, then pop exactly on a completing edge (no drop), then drop.
    tbl[4]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[5]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[6]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[7]  = '{1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, -1};
    // Run B: ready low, FF and 00 dropped.
    tbl[8]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[9]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1};
    tbl[10] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, -1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1};

    Rst        = 1'b1;
    Start      = 1'b0;
    Din        = 1'b1;
    Dout_ready = 1'b0;
    tick();
    tick();
    chk("reset dout",    32'(Dout),       32'h0);
    chk("reset vld",     32'(Dout_valid), 32'h0);
    chk("reset busy",    32'(Busy),       32'h0);
    chk("reset done",    32'(Done),       32'h0);
    chk("reset ovf",     32'(Overflow),   32'h0);
    chk("reset toggles", 32'(Toggles),    32'h0);
    Rst = 1'b0;
    tick();
    tick();

    // Run A
    for (int i = 0; i < 4; i++) apply_row(i);
    tick();
    chk("runA vld one cycle", 32'(Dout_valid), 32'h0);
    chk("runA done pulse",    32'(Done),       32'h0);
    chk("runA idle",          32'(Busy),       32'h0);

    // Run C
    for (int i = 4; i < 8; i++) apply_row(i);
    Dout_ready = 1'b1;
    tick();
    chk("runC pop1 dout", 32'(Dout),       32'h33);
    chk("runC pop1 vld",  32'(Dout_valid), 32'h1);
    chk("runC done drop", 32'(Done),       32'h0);
    tick();
    chk("runC pop2 empty", 32'(Dout_valid), 32'h0);
    Dout_ready = 1'b0;

    // Reset 3 bits into a word
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Din = 1'b1; tick();
    Din = 1'b1; tick();
    Din = 1'b0; tick();
    chk("abort pre busy", 32'(Busy), 32'h1);
    Rst = 1'b1;
    #1;
    chk("abort dout",    32'(Dout),       32'h0);
    chk("abort vld",     32'(Dout_valid), 32'h0);
    chk("abort busy",    32'(Busy),       32'h0);
    chk("abort done",    32'(Done),       32'h0);
    chk("abort ovf",     32'(Overflow),   32'h0);
    chk("abort toggles", 32'(Toggles),    32'h0);
    tick();
    Rst = 1'b0;
    tick();
    chk("abort no done", 32'(Done), 32'h0);
    chk("abort idle",    32'(Busy), 32'h0);

    // Run B
    for (int i = 8; i < 12; i++) apply_row(i);
    Dout_ready = 1'b1;
    tick();
    chk("runB pop1 dout", 32'(Dout),       32'h3C);
    chk("runB pop1 vld",  32'(Dout_valid), 32'h1);
    tick();
    chk("runB pop2 empty", 32'(Dout_valid), 32'h0);
    chk("runB ovf sticky", 32'(Overflow),   32'h1);
    Dout_ready = 1'b0;

    // Toggle saturation: 70000 toggles after a priming sample.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    Din = 1'b0;
    tick();
    for (int i = 0; i < 65534; i++) begin
      Din = ~Din;
      tick();
    end
    chk("toggles pre-sat", 32'(Toggles), 32'hFFFE);
    for (int i = 65534; i < 70000; i++) begin
      Din = ~Din;
      tick();
    end
    chk("toggles saturated", 32'(Toggles), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
